axi4lite_sram_slave: RTL and testbench

AXI4LITE_SRAM_SLAVE -- requirements
Module: axi4lite_sram_slave

---
 rtl/axi4lite_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi4lite_sram_slave.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave over word-addressed SRAM: independent AW/W holders,
// byte-strobed single-beat write commit, and a fixed-latency read FSM.
module axi4lite_sram_slave #(
    parameter int MEM_WORDS = 256,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 =
        (READ_LAT == 0) ? 4'd0 : 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    logic [31:0] mem [MEM_WORDS];

    // Keeps all readies low while in reset and until the first edge after
    logic up_q;

    logic          aw_full;
    logic          w_full;
    logic          bvalid_q;
    logic [AW-1:0] aw_idx_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;

    logic          aw_hs;
    logic          w_hs;
    logic          commit;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    rd_state_t     state;
    rd_state_t     state_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [AW-1:0] ar_idx_q;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rdata_q;
    logic          ar_hs;
    logic          load_r;

    logic unused_ok;
    assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot,
                         mem_axi_awaddr[31:AW+2], mem_axi_awaddr[1:0],
                         mem_axi_araddr[31:AW+2], mem_axi_araddr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            up_q <= 1'b0;
        end else begin
            up_q <= 1'b1;
        end
    end

    assign mem_axi_awready = up_q && !aw_full && !bvalid_q;
    assign mem_axi_wready  = up_q && !w_full && !bvalid_q;
    assign mem_axi_bvalid  = bvalid_q;

    assign aw_hs  = mem_axi_awvalid && mem_axi_awready;
    assign w_hs   = mem_axi_wvalid && mem_axi_wready;
    assign commit = (aw_full || aw_hs) && (w_full || w_hs);

    // Commit takes whichever side is already held, else the live bus value
    assign wr_idx  = aw_full ? aw_idx_q : mem_axi_awaddr[AW+1:2];
    assign wr_data = w_full ? w_data_q : mem_axi_wdata;
    assign wr_strb = w_full ? w_strb_q : mem_axi_wstrb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
        end else begin
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= mem_axi_awaddr[AW+1:2];
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= mem_axi_wdata;
                w_strb_q <= mem_axi_wstrb;
            end
            if (bvalid_q && mem_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign mem_axi_arready = up_q && (state == R_IDLE);
    assign mem_axi_rvalid  = (state == R_RESP);
    assign mem_axi_rdata   = rdata_q;
    assign ar_hs = mem_axi_arvalid && mem_axi_arready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= R_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        load_r  = 1'b0;
        rd_idx  = ar_idx_q;
        unique case (state)
            R_IDLE: begin
                if (ar_hs) begin
                    cnt_d  = '0;
                    rd_idx = mem_axi_araddr[AW+1:2];
                    if (READ_LAT == 0) begin
                        state_d = R_RESP;
                        load_r  = 1'b1;
                    end else begin
                        state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_d = R_RESP;
                    load_r  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            R_RESP: begin
                if (mem_axi_rready) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Sampling on entry to R_RESP sees pre-commit data for a same-edge write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            ar_idx_q <= '0;
            rdata_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (ar_hs) begin
                ar_idx_q <= mem_axi_araddr[AW+1:2];
            end
            if (load_r) begin
                rdata_q <= mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Self-checking bench for axi4lite_sram_slave: vector table, directed
// corner sequences and randomized traffic against a word-array model.
module tb_axi4lite_sram_slave;

    localparam int MW = 256;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [MW];

    typedef struct packed {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    axi4lite_sram_slave #(
        .MEM_WORDS(MW),
        .READ_LAT (RL)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_axi_awvalid(awvalid),
        .mem_axi_awready(awready),
        .mem_axi_awaddr (awaddr),
        .mem_axi_awprot (awprot),
        .mem_axi_wvalid (wvalid),
        .mem_axi_wready (wready),
        .mem_axi_wdata  (wdata),
        .mem_axi_wstrb  (wstrb),
        .mem_axi_bvalid (bvalid),
        .mem_axi_bready (bready),
        .mem_axi_arvalid(arvalid),
        .mem_axi_arready(arready),
        .mem_axi_araddr (araddr),
        .mem_axi_arprot (arprot),
        .mem_axi_rvalid (rvalid),
        .mem_axi_rready (rready),
        .mem_axi_rdata  (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        end
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts and ends just after a rising edge
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int ad, input int wd,
                            output int nb);
        int cyc;
        bit awd, wdn;
        cyc = 0;
        awd = 0;
        wdn = 0;
        nb = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        bready = 1'b1;
        while (!(awd && wdn) && cyc < 40) begin
            awvalid = !awd && (cyc >= ad);
            wvalid  = !wdn && (cyc >= wd);
            @(negedge clk);
            if (awvalid && awready) awd = 1;
            if (wvalid && wready) wdn = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (!(awd && wdn)) chk("write_accept_timeout", 32'(awd && wdn), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (bvalid) nb++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        lat = -1;
        d = '0;
        araddr = a;
        arvalid = 1'b1;
        rready = 1'b1;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = arready;
            @(posedge clk);
            #1;
            n++;
        end
        arvalid = 1'b0;
        if (!ok) chk("ar_accept_timeout", 32'(ok), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rvalid) begin
                d = rdata;
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_model(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string nm);
        int nb;
        do_write(a, d, s, 0, 0, nb);
        chk({nm, "_bcount"}, 32'(nb), 32'd1);
        model[widx(a)] = merge(model[widx(a)], d, s);
    endtask

    task automatic rd_check(input logic [31:0] a, input string nm);
        logic [31:0] d;
        int lat;
        do_read(a, d, lat);
        chk(nm, d, model[widx(a)]);
    endtask

    initial begin
        logic [31:0] d, old, n1, n2;
        int lat, nb, ok;

        resetn = 1'b0;
        awvalid = 0; awaddr = 0; awprot = 0;
        wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0;
        arvalid = 0; araddr = 0; arprot = 0;
        rready = 0;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h10, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0404, 32'hA5A5_A5A5, 4'hF, 32'h04, 32'hA5A5_A5A5};
        vecs[2] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'h20, 32'h1122_3344};
        vecs[3] = '{32'h0000_0022, 32'hFFFF_FFFF, 4'h8, 32'h20, 32'hFF22_3344};
        vecs[4] = '{32'h0000_0020, 32'h0000_0000, 4'h0, 32'h20, 32'hFF22_3344};
        vecs[5] = '{32'h0000_0420, 32'h0000_00AA, 4'h1, 32'h20, 32'hFF22_33AA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_valid",
            32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 32'({awready, wready, arready}), 32'd7);

        for (int i = 0; i < MW; i++) begin
            d = $urandom;
            do_write(32'(i * 4), d, 4'hF, 0, 0, nb);
            model[i] = d;
        end

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, 0, 0, nb);
            model[widx(vecs[i].wa)] =
                merge(model[widx(vecs[i].wa)], vecs[i].wd, vecs[i].ws);
            chk($sformatf("vec%0d_bcount", i), 32'(nb), 32'd1);
            do_read(vecs[i].ra, d, lat);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(RL));
        end

        // W before AW, merged over an old word
        wr_model(32'h10, 32'hDEAD_BEEF, 4'hF, "wfirst_pre");
        wdata = 32'h1234_5678;
        wstrb = 4'b0101;
        wvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", 32'(wready), 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        nb = 0;
        awaddr = 32'h10;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) awvalid = 1'b1;
            @(negedge clk);
            if (bvalid) nb++;
            @(posedge clk);
            #1;
            awvalid = 1'b0;
        end
        repeat (4) begin
            @(negedge clk);
            if (bvalid) nb++;
        end
        @(posedge clk);
        #1;
        chk("wfirst_bcount", 32'(nb), 32'd1);
        model[4] = merge(model[4], 32'h1234_5678, 4'b0101);
        do_read(32'h10, d, lat);
        chk("wfirst_rdata", d, 32'hDE34_BE78);

        // Response backpressure
        awaddr = 32'h30;
        wdata = 32'hCAFE_F00D;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", 32'({awready, wready}), 32'd3);
        @(posedge clk);
        #1;
        awaddr = 32'h34;
        wdata = 32'h0BAD_CAFE;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(bvalid && !awready && !wready)) ok = 0;
            @(posedge clk);
            #1;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_next_accept", 32'({bvalid, awready, wready}), 32'b011);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("bp_next_resp", 32'(bvalid), 32'd1);
        @(posedge clk);
        #1;
        model[12] = 32'hCAFE_F00D;
        model[13] = 32'h0BAD_CAFE;
        rd_check(32'h30, "bp_rd30");
        rd_check(32'h34, "bp_rd34");

        // Read held in R_RESP while writes to the same word commit
        old = model[8];
        n1 = 32'h5555_0001;
        n2 = 32'h5555_0002;
        araddr = 32'h20;
        arvalid = 1'b1;
        rready = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        repeat (RL - 1) begin
            @(posedge clk);
            #1;
        end
        awaddr = 32'h20;
        wdata = n1;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                wdata = n2;
                awvalid = 1'b1;
                wvalid = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("rhold_data%0d", i), rdata, old);
            chk($sformatf("rhold_valid%0d", i), 32'(rvalid), 32'd1);
            @(posedge clk);
            #1;
            awvalid = 1'b0;
            wvalid = 1'b0;
        end
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        model[8] = n2;
        rd_check(32'h20, "rhold_after");

        // Reset in R_WAIT with an AW held
        araddr = 32'h40;
        awaddr = 32'h44;
        arvalid = 1'b1;
        awvalid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        resetn = 1'b0;
        wdata = 32'h7777_7777;
        wstrb = 4'hF;
        wvalid = 1'b1;
        #1;
        chk("mid_reset_outputs",
            32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        chk("mid_reset_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_ready", 32'({awready, wready, arready}), 32'd7);
        chk("mid_reset_valid", 32'({bvalid, rvalid}), 32'd0);
        rd_check(32'h44, "mid_reset_store");

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a, wdv;
            logic [3:0] s;
            a = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                do_read(a, d, lat);
                chk("rand_rdata", d, model[widx(a)]);
                chk("rand_lat", 32'(lat), 32'(RL));
            end else begin
                wdv = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, wdv, s, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), nb);
                chk("rand_bcount", 32'(nb), 32'd1);
                model[widx(a)] = merge(model[widx(a)], wdv, s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
